// File: rtl/accel_bus_initiator.sv
// Host-side initiator for the 4-bit-address / 8-bit-data peripheral register bus.
// Turns valid/ready burst commands into bus write strobes fed from a write-data
// stream, or into paced bus reads that are returned on a response stream.
module accel_bus_initiator #(
  parameter int READ_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [3:0] cmd_addr,
  input  logic [3:0] cmd_len,
  input  logic       cmd_incr,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic       busy,
  output logic [3:0] p_address,
  output logic       p_data_write,
  output logic [7:0] p_data_in,
  input  logic [7:0] p_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_WAIT,
    RD_SAMPLE,
    RD_RESP
  } state_t;

  localparam logic [2:0] WAIT_INIT  = 3'(READ_WAIT);
  localparam state_t     READ_ENTRY = (READ_WAIT > 0) ? RD_WAIT : RD_SAMPLE;

  state_t     state, state_nxt;
  logic [3:0] remaining, remaining_nxt;
  logic       incr, incr_nxt;
  logic [2:0] wait_cnt, wait_nxt;
  logic [3:0] p_address_nxt;
  logic       rsp_valid_nxt;
  logic [7:0] rsp_data_nxt;
  logic       rsp_last_nxt;
  logic [3:0] addr_step;

  // Address of the following beat: 4-bit wrap when incrementing, otherwise held.
  assign addr_step = incr ? (p_address + 4'd1) : p_address;

  // Handshake and bus strobes; all forced low while reset is asserted.
  assign cmd_ready    = rst_n & (state == IDLE);
  assign wr_ready     = rst_n & (state == WRITE);
  assign p_data_write = rst_n & (state == WRITE) & wr_valid;
  assign p_data_in    = wr_data;
  assign busy         = rst_n & (state != IDLE);

  // Next-state and datapath decisions; the last beat exits before remaining decrements.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    incr_nxt      = incr;
    wait_nxt      = wait_cnt;
    p_address_nxt = p_address;
    rsp_valid_nxt = rsp_valid;
    rsp_data_nxt  = rsp_data;
    rsp_last_nxt  = rsp_last;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          p_address_nxt = cmd_addr;
          remaining_nxt = cmd_len;
          incr_nxt      = cmd_incr;
          if (cmd_write) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = READ_ENTRY;
            wait_nxt  = WAIT_INIT;
          end
        end
      end
      WRITE: begin
        if (wr_valid) begin
          if (remaining == 4'd0) begin
            state_nxt = IDLE;
          end else begin
            remaining_nxt = remaining - 4'd1;
            p_address_nxt = addr_step;
          end
        end
      end
      RD_WAIT: begin
        if (wait_cnt <= 3'd1) begin
          state_nxt = RD_SAMPLE;
        end else begin
          wait_nxt = wait_cnt - 3'd1;
        end
      end
      RD_SAMPLE: begin
        rsp_data_nxt  = p_data_out;
        rsp_valid_nxt = 1'b1;
        rsp_last_nxt  = (remaining == 4'd0);
        state_nxt     = RD_RESP;
      end
      RD_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          if (rsp_last) begin
            state_nxt = IDLE;
          end else begin
            remaining_nxt = remaining - 4'd1;
            p_address_nxt = addr_step;
            state_nxt     = READ_ENTRY;
            wait_nxt      = WAIT_INIT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= 4'd0;
      incr      <= 1'b0;
      wait_cnt  <= 3'd0;
      p_address <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'd0;
      rsp_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      incr      <= incr_nxt;
      wait_cnt  <= wait_nxt;
      p_address <= p_address_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_last  <= rsp_last_nxt;
    end
  end

endmodule

// File: tb/tb_accel_bus_initiator.sv
// Testbench for accel_bus_initiator: directed bursts, reset abort, and
// randomized command/data/backpressure traffic against a burst-level model.
module tb_accel_bus_initiator;

  localparam int RW = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_write, cmd_incr;
  logic [3:0] cmd_addr, cmd_len;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rsp_ready;
  logic       cmd_ready, wr_ready, rsp_valid, rsp_last, busy, p_data_write;
  logic [7:0] rsp_data, p_data_in, p_data_out;
  logic [3:0] p_address;

  logic       b_cmd_valid, b_cmd_write, b_cmd_incr, b_wr_valid, b_rsp_ready;
  logic [3:0] b_cmd_addr, b_cmd_len;
  logic [7:0] b_wr_data;
  logic       b_cmd_ready, b_wr_ready, b_rsp_valid, b_rsp_last, b_busy, b_p_data_write;
  logic [7:0] b_rsp_data, b_p_data_in, b_p_data_out;
  logic [3:0] b_p_address;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  logic chk_en    = 1'b0;
  logic rand_mode = 1'b0;
  logic mem_load  = 1'b1;
  int   st_cnt    = 0;

  logic [7:0] per_mem [16];
  logic [7:0] ref_mem [16];

  int         m_mode;
  int         m_cnt;
  logic [3:0] m_addr, m_left;
  logic       m_incr, m_rv, m_rl;
  logic [7:0] m_rd;

  logic [7:0] rx_data[$];
  logic       rx_last[$];
  int         rx_cyc[$];
  logic [7:0] b_rx_data[$];
  logic       b_rx_last[$];
  int         b_rx_cyc[$];
  logic [3:0] b_rx_addr[$];

  accel_bus_initiator #(.READ_WAIT(RW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_incr(cmd_incr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .p_address(p_address), .p_data_write(p_data_write),
    .p_data_in(p_data_in), .p_data_out(p_data_out)
  );

  accel_bus_initiator #(.READ_WAIT(3)) u_dut_w3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_addr(b_cmd_addr), .cmd_len(b_cmd_len), .cmd_incr(b_cmd_incr),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_last(b_rsp_last),
    .busy(b_busy), .p_address(b_p_address), .p_data_write(b_p_data_write),
    .p_data_in(b_p_data_in), .p_data_out(b_p_data_out)
  );

  always #5 clk = ~clk;

  // Cycle counter: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral register file: preloaded with addr^0x5A, written by bus strobes.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) per_mem[i] <= 8'(i) ^ 8'h5A;
    end else if (p_data_write) begin
      per_mem[p_address] <= p_data_in;
    end
  end

  assign p_data_out   = per_mem[p_address];
  assign b_p_data_out = {4'h0, b_p_address} ^ 8'h5A;

  // Burst-level expectation: mode 0 idle, 1 writing, 2 reading; m_cnt counts
  // edges until the next read sample lands on the response port.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    if (!rst_n) begin
      m_mode = 0; m_addr = 4'd0; m_left = 4'd0; m_incr = 1'b0;
      m_rv = 1'b0; m_rd = 8'd0; m_rl = 1'b0; m_cnt = 0;
    end else begin
      case (m_mode)
        0: if (cmd_valid) begin
          m_addr = cmd_addr; m_left = cmd_len; m_incr = cmd_incr;
          if (cmd_write) m_mode = 1;
          else begin m_mode = 2; m_cnt = RW + 1; end
        end
        1: if (wr_valid) begin
          ref_mem[m_addr] = wr_data;
          if (m_left == 4'd0) m_mode = 0;
          else begin m_left = m_left - 4'd1; m_addr = 4'(m_addr + {3'b000, m_incr}); end
        end
        default: begin
          if (m_rv) begin
            if (rsp_ready) begin
              m_rv = 1'b0;
              if (m_rl) m_mode = 0;
              else begin
                m_left = m_left - 4'd1;
                m_addr = 4'(m_addr + {3'b000, m_incr});
                m_cnt  = RW + 1;
              end
            end
          end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
              m_rv = 1'b1; m_rd = ref_mem[m_addr]; m_rl = (m_left == 4'd0);
            end
          end
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // One clock: compare at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en && rst_n) begin
      checkOutput("cmd_ready", 8'(cmd_ready), 8'(m_mode == 0));
      checkOutput("busy", 8'(busy), 8'(m_mode != 0));
      checkOutput("wr_ready", 8'(wr_ready), 8'(m_mode == 1));
      checkOutput("p_data_write", 8'(p_data_write), 8'((m_mode == 1) && wr_valid));
      checkOutput("p_data_in", p_data_in, wr_data);
      checkOutput("p_address", {4'h0, p_address}, {4'h0, m_addr});
      checkOutput("rsp_valid", 8'(rsp_valid), 8'(m_rv));
      checkOutput("rsp_data", rsp_data, m_rd);
      checkOutput("rsp_last", 8'(rsp_last), 8'(m_rl));
      checkOutput("b_no_write", 8'(b_p_data_write | b_wr_ready), 8'h00);
      checkOutput("b_p_data_in", b_p_data_in, b_wr_data);
    end
    if (rsp_valid && rsp_ready) begin
      rx_data.push_back(rsp_data); rx_last.push_back(rsp_last); rx_cyc.push_back(cyc + 1);
    end
    if (b_rsp_valid && b_rsp_ready) begin
      b_rx_data.push_back(b_rsp_data); b_rx_last.push_back(b_rsp_last);
      b_rx_cyc.push_back(cyc + 1); b_rx_addr.push_back(b_p_address);
    end
    if (p_data_write) st_cnt++;
    @(posedge clk);
    #1;
    if (rand_mode) begin
      wr_valid  = ($urandom_range(0, 3) != 0);
      wr_data   = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [3:0] l,
                               input logic inc, output int t_acc);
    int n;
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_incr = inc; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 500) begin tick(); n++; end
    if (n >= 500) checkOutput("cmd_accept_timeout", 8'h01, 8'h00);
    tick();
    t_acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic feedWrite(input logic [7:0] d);
    int n;
    wr_data = d; wr_valid = 1'b1;
    n = 0;
    while (!wr_ready && n < 100) begin tick(); n++; end
    if (n >= 100) checkOutput("wr_ready_timeout", 8'h01, 8'h00);
    tick();
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    if (n >= 2000) checkOutput("idle_timeout", 8'h01, 8'h00);
  endtask

  initial begin
    int t;
    int s0;
    logic [7:0] exp_rd [3];
    logic       exp_last [3];
    exp_rd[0] = 8'h59; exp_rd[1] = 8'h5E; exp_rd[2] = 8'h5F;
    exp_last[0] = 1'b0; exp_last[1] = 1'b0; exp_last[2] = 1'b1;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'd0; cmd_len = 4'd0;
    cmd_incr = 1'b0; wr_valid = 1'b0; wr_data = 8'd0; rsp_ready = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = 4'd0; b_cmd_len = 4'd0;
    b_cmd_incr = 1'b0; b_wr_valid = 1'b0; b_wr_data = 8'h00; b_rsp_ready = 1'b0;

    repeat (3) tick();
    mem_load = 1'b0;
    checkOutput("rst_p_address", {4'h0, p_address}, 8'h00);
    checkOutput("rst_rsp_valid", 8'(rsp_valid), 8'h00);
    checkOutput("rst_rsp_data", rsp_data, 8'h00);
    checkOutput("rst_rsp_last", 8'(rsp_last), 8'h00);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_cmd_ready", 8'(cmd_ready), 8'h01);
    checkOutput("rst_busy", 8'(busy), 8'h00);
    chk_en = 1'b1;

    // Single write with wr_valid held past the burst.
    wr_data = 8'hA5; wr_valid = 1'b1;
    s0 = st_cnt;
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, t);
    repeat (4) tick();
    wr_valid = 1'b0;
    checkOutput("single_strobes", 8'(st_cnt - s0), 8'h01);
    checkOutput("single_mem0", per_mem[0], 8'hA5);

    // Incrementing write wrapping E,F,0,1 with a two-cycle data gap.
    s0 = st_cnt;
    applyStimulus(1'b1, 4'hE, 4'h3, 1'b1, t);
    feedWrite(8'h11); feedWrite(8'h22);
    wr_valid = 1'b0;
    repeat (2) tick();
    feedWrite(8'h33); feedWrite(8'h44);
    wr_valid = 1'b0;
    tick();
    checkOutput("wrap_strobes", 8'(st_cnt - s0), 8'h04);
    checkOutput("wrap_memE", per_mem[14], 8'h11);
    checkOutput("wrap_memF", per_mem[15], 8'h22);
    checkOutput("wrap_mem0", per_mem[0], 8'h33);
    checkOutput("wrap_mem1", per_mem[1], 8'h44);

    // Read burst 3..5 with rsp_ready high.
    rx_data.delete(); rx_last.delete(); rx_cyc.delete();
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 4'h3, 4'h2, 1'b1, t);
    waitIdle();
    tick();
    checkOutput("rd_count", 8'(rx_data.size()), 8'h03);
    for (int i = 0; i < 3; i++) begin
      if (i < rx_data.size()) begin
        checkOutput("rd_data", rx_data[i], exp_rd[i]);
        checkOutput("rd_last", 8'(rx_last[i]), 8'(exp_last[i]));
        checkOutput("rd_timing", 8'(rx_cyc[i] - t), 8'(2 + 2 * i));
      end
    end

    // Same read with beat 1 held off for five cycles.
    rx_data.delete(); rx_last.delete(); rx_cyc.delete();
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 4'h3, 4'h2, 1'b1, t);
    s0 = 0;
    while (!rsp_valid && s0 < 50) begin tick(); s0++; end
    repeat (5) tick();
    checkOutput("bp_addr", {4'h0, p_address}, 8'h03);
    checkOutput("bp_data", rsp_data, 8'h59);
    rsp_ready = 1'b1;
    waitIdle();
    tick();
    checkOutput("bp_count", 8'(rx_data.size()), 8'h03);
    for (int i = 0; i < 3; i++) begin
      if (i < rx_data.size()) begin
        checkOutput("bp_rd_data", rx_data[i], exp_rd[i]);
        checkOutput("bp_rd_last", 8'(rx_last[i]), 8'(exp_last[i]));
      end
    end

    // Fixed-address read on the READ_WAIT=3 instance.
    b_rsp_ready = 1'b1;
    b_cmd_addr = 4'h7; b_cmd_len = 4'h1; b_cmd_incr = 1'b0; b_cmd_write = 1'b0;
    b_cmd_valid = 1'b1;
    tick();
    t = cyc;
    b_cmd_valid = 1'b0;
    s0 = 0;
    while (b_busy && s0 < 40) begin tick(); s0++; end
    tick();
    checkOutput("w3_count", 8'(b_rx_data.size()), 8'h02);
    for (int i = 0; i < 2; i++) begin
      if (i < b_rx_data.size()) begin
        checkOutput("w3_data", b_rx_data[i], 8'h5D);
        checkOutput("w3_addr", {4'h0, b_rx_addr[i]}, 8'h07);
        checkOutput("w3_last", 8'(b_rx_last[i]), 8'(i == 1));
        checkOutput("w3_timing", 8'(b_rx_cyc[i] - t), 8'(5 + 5 * i));
      end
    end
    checkOutput("w3_idle", 8'({b_cmd_ready, b_busy}), 8'h02);

    // Reset during beat 2 of an 8-beat write, then a fresh single write.
    applyStimulus(1'b1, 4'h4, 4'h7, 1'b1, t);
    feedWrite(8'h61);
    wr_data = 8'h62; wr_valid = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("abort_strobe", 8'(p_data_write), 8'h00);
    checkOutput("abort_addr", {4'h0, p_address}, 8'h00);
    checkOutput("abort_busy", 8'(busy), 8'h00);
    checkOutput("abort_rsp_valid", 8'(rsp_valid), 8'h00);
    checkOutput("abort_mem4", per_mem[4], 8'h61);
    checkOutput("abort_mem5", per_mem[5], 8'h5F);
    wr_valid = 1'b0;
    wr_data = 8'h3C; wr_valid = 1'b1;
    applyStimulus(1'b1, 4'h9, 4'h0, 1'b0, t);
    tick();
    wr_valid = 1'b0;
    tick();
    checkOutput("post_abort_mem9", per_mem[9], 8'h3C);

    // Randomized mixed traffic, commands offered back to back.
    rand_mode = 1'b1;
    for (int k = 0; k < 60; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)), t);
    end
    rand_mode = 1'b0;
    wr_valid = 1'b1; rsp_ready = 1'b1;
    waitIdle();
    wr_valid = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
